// File: rtl/fpu_inv_sqrt_iter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_inv_sqrt_iter_if : operand / result valid-ready bundle for fpu_inv_sqrt_iter
// Revision 1.0
// ----------------------------------------------------------------------------
interface fpu_inv_sqrt_iter_if;
  logic        iValid;
  logic        oInReady;
  logic [31:0] iA;
  logic        iMode;
  logic        oValid;
  logic        iReady;
  logic [31:0] oResult;

  modport master (
    output iValid, iA, iMode, iReady,
    input  oInReady, oValid, oResult
  );

  modport slave (
    input  iValid, iA, iMode, iReady,
    output oInReady, oValid, oResult
  );
endinterface
`default_nettype wire

// File: rtl/fpu_inv_sqrt_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_inv_sqrt_iter : iterative FP32 1/sqrt(x) or sqrt(x), magic seed + Newton
// Revision 1.0
// ----------------------------------------------------------------------------
module fpu_inv_sqrt_iter #(
  parameter int unsigned ITERS = 2,
  parameter logic [31:0] MAGIC = 32'h5f3759df
) (
  input  logic                iCLK,
  input  logic                iRESET,
  fpu_inv_sqrt_iter_if.slave  bus
);

  if (ITERS > 3) begin : g_iters_check
    $error("fpu_inv_sqrt_iter: ITERS must be in 0..3");
  end

  localparam logic [1:0]  LAST_ITER = 2'((ITERS == 0) ? 0 : ITERS - 1);
  localparam logic [25:0] ONE_HALF_Q = 26'h1800000;
  localparam logic [31:0] QNAN       = 32'h7fc00000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEED = 3'd1,
    S_SQ   = 3'd2,
    S_MH   = 3'd3,
    S_SUB  = 3'd4,
    S_MY   = 3'd5,
    S_SQM  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] x_q, x_d;
  logic [31:0] h_q, h_d;
  logic [31:0] y_q, y_d;
  logic [31:0] t_q, t_d;     // holds t through MH, then u after SUB
  logic [31:0] res_q, res_d;
  logic        mode_q, mode_d;
  logic [1:0]  iter_q, iter_d;

  logic [31:0] mul_a, mul_b, mul_p;
  logic [31:0] sub_u;
  logic [31:0] seed_y;
  logic [31:0] seed_h;
  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic        in_sign;
  logic        is_special;
  logic [31:0] spec_res;

  // FP32 multiply for normal operands: truncated mantissa, underflow to +0.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [9:0]  e;
    logic [22:0] m;
    logic        s;
    s = a[31] ^ b[31];
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 10'd1;
    end else begin
      m = p[45:23];
    end
    if ((a[30:23] == 8'd0) || (b[30:23] == 8'd0) || e[9] || (e == 10'd0)) begin
      return 32'h00000000;
    end else if (e >= 10'd255) begin
      return {s, 8'hff, 23'd0};
    end
    return {s, e[7:0], m};
  endfunction

  // u = 1.5 - t computed in unsigned Q2.24, then renormalised with truncation.
  function automatic logic [31:0] half3_minus(input logic [30:0] t);
    logic [47:0] wide;
    logic [25:0] tf;
    logic [25:0] uf;
    logic [25:0] norm;
    logic [7:0]  sh;
    logic [4:0]  lead;
    logic        found;
    tf = 26'd0;
    if (t[30:23] > 8'd127) begin
      tf = ONE_HALF_Q;
    end else if (t[30:23] > 8'd102) begin
      sh   = 8'd150 - t[30:23];
      wide = {1'b1, t[22:0], 24'd0} >> sh;
      tf   = wide[25:0];
    end
    uf    = ONE_HALF_Q - tf;
    lead  = 5'd0;
    found = 1'b0;
    for (int i = 0; i < 26; i++) begin
      if (uf[i]) begin
        lead  = 5'(i);
        found = 1'b1;
      end
    end
    if (!found) begin
      return 32'h00000000;
    end
    norm = uf << (5'd25 - lead);
    return {1'b0, 8'd103 + {3'b000, lead}, norm[24:2]};
  endfunction

  assign in_sign = bus.iA[31];
  assign in_exp  = bus.iA[30:23];
  assign in_frac = bus.iA[22:0];

  // Denormals count as signed zero; negative nonzero and NaN collapse to qNaN.
  assign is_special = (in_exp == 8'd0) || (in_exp == 8'hff) || in_sign;

  always_comb begin
    spec_res = QNAN;
    if (in_exp == 8'd0) begin
      spec_res = bus.iMode ? {in_sign, 31'd0} : {in_sign, 8'hff, 23'd0};
    end else if ((in_exp == 8'hff) && (in_frac == 23'd0) && !in_sign) begin
      spec_res = bus.iMode ? 32'h7f800000 : 32'h00000000;
    end
  end

  assign seed_y = MAGIC - {1'b0, x_q[31:1]};
  assign seed_h = {x_q[31], x_q[30:23] - 8'd1, x_q[22:0]};
  assign sub_u  = half3_minus(t_q[30:0]);

  always_comb begin
    mul_a = y_q;
    mul_b = y_q;
    case (state_q)
      S_MH:    begin mul_a = h_q; mul_b = t_q; end
      S_MY:    begin mul_a = y_q; mul_b = t_q; end
      S_SQM:   begin mul_a = x_q; mul_b = y_q; end
      default: ;
    endcase
  end

  assign mul_p = fmul(mul_a, mul_b);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    h_d     = h_q;
    y_d     = y_q;
    t_d     = t_q;
    res_d   = res_q;
    mode_d  = mode_q;
    iter_d  = iter_q;
    case (state_q)
      S_IDLE: begin
        if (bus.iValid) begin
          if (is_special) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end else begin
            x_d     = bus.iA;
            mode_d  = bus.iMode;
            state_d = S_SEED;
          end
        end
      end
      S_SEED: begin
        y_d    = seed_y;
        h_d    = seed_h;
        iter_d = 2'd0;
        if (ITERS == 0) begin
          if (mode_q) begin
            state_d = S_SQM;
          end else begin
            res_d   = seed_y;
            state_d = S_DONE;
          end
        end else begin
          state_d = S_SQ;
        end
      end
      S_SQ: begin
        t_d     = mul_p;
        state_d = S_MH;
      end
      S_MH: begin
        t_d     = mul_p;
        state_d = S_SUB;
      end
      S_SUB: begin
        t_d     = sub_u;
        state_d = S_MY;
      end
      S_MY: begin
        y_d = mul_p;
        if (iter_q == LAST_ITER) begin
          if (mode_q) begin
            state_d = S_SQM;
          end else begin
            res_d   = mul_p;
            state_d = S_DONE;
          end
        end else begin
          iter_d  = iter_q + 2'd1;
          state_d = S_SQ;
        end
      end
      S_SQM: begin
        y_d     = mul_p;
        res_d   = mul_p;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.iReady) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q <= S_IDLE;
      x_q     <= 32'd0;
      h_q     <= 32'd0;
      y_q     <= 32'd0;
      t_q     <= 32'd0;
      res_q   <= 32'd0;
      mode_q  <= 1'b0;
      iter_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      h_q     <= h_d;
      y_q     <= y_d;
      t_q     <= t_d;
      res_q   <= res_d;
      mode_q  <= mode_d;
      iter_q  <= iter_d;
    end
  end

  assign bus.oInReady = (state_q == S_IDLE);
  assign bus.oValid   = (state_q == S_DONE);
  assign bus.oResult  = res_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_inv_sqrt_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fpu_inv_sqrt_iter : bench for fpu_inv_sqrt_iter with ITERS = 0, 1 and 2
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_fpu_inv_sqrt_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        v_valid [3];
  logic [31:0] v_a     [3];
  logic        v_mode  [3];
  logic        v_ready [3];
  logic        v_inrdy [3];
  logic        v_ovld  [3];
  logic [31:0] v_res   [3];

  fpu_inv_sqrt_iter_if if0 ();
  fpu_inv_sqrt_iter_if if1 ();
  fpu_inv_sqrt_iter_if if2 ();

  assign if0.iValid = v_valid[0];
  assign if0.iA     = v_a[0];
  assign if0.iMode  = v_mode[0];
  assign if0.iReady = v_ready[0];
  assign v_inrdy[0] = if0.oInReady;
  assign v_ovld[0]  = if0.oValid;
  assign v_res[0]   = if0.oResult;

  assign if1.iValid = v_valid[1];
  assign if1.iA     = v_a[1];
  assign if1.iMode  = v_mode[1];
  assign if1.iReady = v_ready[1];
  assign v_inrdy[1] = if1.oInReady;
  assign v_ovld[1]  = if1.oValid;
  assign v_res[1]   = if1.oResult;

  assign if2.iValid = v_valid[2];
  assign if2.iA     = v_a[2];
  assign if2.iMode  = v_mode[2];
  assign if2.iReady = v_ready[2];
  assign v_inrdy[2] = if2.oInReady;
  assign v_ovld[2]  = if2.oValid;
  assign v_res[2]   = if2.oResult;

  fpu_inv_sqrt_iter #(.ITERS(0), .MAGIC(32'h5f3759df)) u_dut0 (.iCLK(clk), .iRESET(rst), .bus(if0));
  fpu_inv_sqrt_iter #(.ITERS(1), .MAGIC(32'h5f3759df)) u_dut1 (.iCLK(clk), .iRESET(rst), .bus(if1));
  fpu_inv_sqrt_iter #(.ITERS(2), .MAGIC(32'h5f3759df)) u_dut2 (.iCLK(clk), .iRESET(rst), .bus(if2));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int          k;
    logic [31:0] a;
    logic        mode;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vt [15];

  function automatic real f2r(input logic [31:0] b);
    real m;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    if (e > 0) for (int i = 0; i < e; i++) m = m * 2.0;
    else       for (int i = 0; i < -e; i++) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction

  // Reference: exact real-valued result of the requested operation.
  function automatic real ref_op(input logic [31:0] a, input logic mode);
    real x;
    x = f2r(a);
    return mode ? $sqrt(x) : 1.0 / $sqrt(x);
  endfunction

  function automatic logic [31:0] rand_normal();
    logic [31:0] r;
    logic [7:0]  e;
    r = $urandom;
    e = 8'($urandom_range(190, 64));
    return {1'b0, e, r[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_rel(input string name, input logic [31:0] act, input real r, input real tol);
    real got;
    real err;
    got = f2r(act);
    err = (got - r) / r;
    if (err < 0.0) err = -err;
    n_chk++;
    if (!(err <= tol) || act[30:23] == 8'hff || act[30:23] == 8'd0) begin
      n_fail++;
      $display("FAIL %s: got %h (%g), expected %g within rel %g", name, act, got, r, tol);
    end
  endtask

  // One operation with iReady held high; lat counts negedges after the accepting edge.
  task automatic run_op(input int k, input logic [31:0] a, input logic mode,
                        output logic [31:0] res, output int lat);
    int guard;
    @(negedge clk);
    v_valid[k] = 1'b1;
    v_a[k]     = a;
    v_mode[k]  = mode;
    v_ready[k] = 1'b1;
    guard = 0;
    while (!v_inrdy[k] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    v_valid[k] = 1'b0;
    lat = 0;
    while (!v_ovld[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    res = v_res[k];
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] hold;
    logic [31:0] a1;
    logic [31:0] a2;
    int          lat;
    int          seen;
    real         refq[$];
    int          sent;
    int          got;
    int          last_cyc;

    for (int k = 0; k < 3; k++) begin
      v_valid[k] = 1'b0;
      v_a[k]     = 32'd0;
      v_mode[k]  = 1'b0;
      v_ready[k] = 1'b1;
    end

    vt[0]  = '{k:0, a:32'h3f800000, mode:1'b0, exp_res:32'h3f7759df, exp_lat:1};
    vt[1]  = '{k:0, a:32'h41133333, mode:1'b0, exp_res:32'h3eadc046, exp_lat:1};
    vt[2]  = '{k:0, a:32'h40800000, mode:1'b1, exp_res:32'h3ff759df, exp_lat:2};
    vt[3]  = '{k:2, a:32'h00000000, mode:1'b0, exp_res:32'h7f800000, exp_lat:0};
    vt[4]  = '{k:2, a:32'h00000000, mode:1'b1, exp_res:32'h00000000, exp_lat:0};
    vt[5]  = '{k:2, a:32'h80000000, mode:1'b0, exp_res:32'hff800000, exp_lat:0};
    vt[6]  = '{k:2, a:32'h80000000, mode:1'b1, exp_res:32'h80000000, exp_lat:0};
    vt[7]  = '{k:2, a:32'h7f800000, mode:1'b0, exp_res:32'h00000000, exp_lat:0};
    vt[8]  = '{k:2, a:32'h7f800000, mode:1'b1, exp_res:32'h7f800000, exp_lat:0};
    vt[9]  = '{k:2, a:32'h7fc00001, mode:1'b0, exp_res:32'h7fc00000, exp_lat:0};
    vt[10] = '{k:2, a:32'h7fc00001, mode:1'b1, exp_res:32'h7fc00000, exp_lat:0};
    vt[11] = '{k:2, a:32'hc0800000, mode:1'b0, exp_res:32'h7fc00000, exp_lat:0};
    vt[12] = '{k:2, a:32'hc0800000, mode:1'b1, exp_res:32'h7fc00000, exp_lat:0};
    vt[13] = '{k:2, a:32'h00000001, mode:1'b0, exp_res:32'h7f800000, exp_lat:0};
    vt[14] = '{k:2, a:32'h00000001, mode:1'b1, exp_res:32'h00000000, exp_lat:0};

    // Reset held for two edges
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst%0d_ovalid", i), {31'd0, v_ovld[2]}, 32'd0);
      chk($sformatf("rst%0d_result", i), v_res[2], 32'd0);
      chk($sformatf("rst%0d_inready", i), {31'd0, v_inrdy[2]}, 32'd1);
    end
    rst = 1'b0;

    // Reset while the operation sits in MH
    v_valid[2] = 1'b1;
    v_a[2]     = 32'h40800000;
    v_mode[2]  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v_valid[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ovalid", {31'd0, v_ovld[2]}, 32'd0);
    chk("midrst_result", v_res[2], 32'd0);
    chk("midrst_inready", {31'd0, v_inrdy[2]}, 32'd1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (v_ovld[2]) seen++;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);

    // Seed exactness and special cases
    for (int i = 0; i < 15; i++) begin
      run_op(vt[i].k, vt[i].a, vt[i].mode, res, lat);
      chk($sformatf("vec%0d_value", i), res, vt[i].exp_res);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
    end

    // Accuracy, ITERS=2
    run_op(2, 32'h40800000, 1'b0, res, lat);
    chk_rel("acc_rsqrt4", res, 0.5, 5e-6);
    chk("acc_rsqrt4_latency", 32'(lat), 32'd9);
    run_op(2, 32'h41133333, 1'b0, res, lat);
    chk_rel("acc_rsqrt9p2", res, ref_op(32'h41133333, 1'b0), 5e-6);
    run_op(2, 32'h40800000, 1'b1, res, lat);
    chk_rel("acc_sqrt4", res, 2.0, 1e-5);
    chk("acc_sqrt4_latency", 32'(lat), 32'd10);

    for (int i = 0; i < 1000; i++) begin
      a1 = rand_normal();
      run_op(2, a1, 1'b0, res, lat);
      chk_rel($sformatf("sweep2_rsqrt_%h", a1), res, ref_op(a1, 1'b0), 5e-6);
      chk($sformatf("sweep2_latency_%h", a1), 32'(lat), 32'd9);
    end
    for (int i = 0; i < 100; i++) begin
      a1 = rand_normal();
      run_op(2, a1, 1'b1, res, lat);
      chk_rel($sformatf("sweep2_sqrt_%h", a1), res, ref_op(a1, 1'b1), 1e-5);
    end
    for (int i = 0; i < 200; i++) begin
      a1 = rand_normal();
      run_op(1, a1, 1'b0, res, lat);
      chk_rel($sformatf("sweep1_rsqrt_%h", a1), res, ref_op(a1, 1'b0), 2e-3);
      chk($sformatf("sweep1_latency_%h", a1), 32'(lat), 32'd5);
    end

    // Backpressure with a new operand already waiting
    a1 = 32'h42c80000;
    a2 = 32'h3e800000;
    @(negedge clk);
    v_ready[2] = 1'b0;
    v_valid[2] = 1'b1;
    v_a[2]     = a1;
    v_mode[2]  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    v_a[2] = a2;
    lat = 0;
    while (!v_ovld[2] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd9);
    chk_rel("bp_first_result", v_res[2], ref_op(a1, 1'b0), 5e-6);
    hold = v_res[2];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_result", i), v_res[2], hold);
      chk($sformatf("bp_hold%0d_ovalid", i), {31'd0, v_ovld[2]}, 32'd1);
      chk($sformatf("bp_hold%0d_inready", i), {31'd0, v_inrdy[2]}, 32'd0);
    end
    v_ready[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_handshake_inready", {31'd0, v_inrdy[2]}, 32'd1);
    chk("bp_after_handshake_ovalid", {31'd0, v_ovld[2]}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_accepted_next_edge", {31'd0, v_inrdy[2]}, 32'd0);
    v_valid[2] = 1'b0;
    lat = 0;
    while (!v_ovld[2] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_second_latency", 32'(lat), 32'd9);
    chk_rel("bp_second_result", v_res[2], ref_op(a2, 1'b0), 5e-6);
    @(posedge clk);

    // Back-to-back stream of 20 operands
    sent     = 0;
    got      = 0;
    last_cyc = -1;
    v_ready[2] = 1'b1;
    v_mode[2]  = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge clk);
      if (v_ovld[2]) begin
        if (refq.size() > 0) begin
          chk_rel($sformatf("stream%0d_result", got), v_res[2], refq.pop_front(), 5e-6);
        end else begin
          chk($sformatf("stream%0d_unexpected", got), {31'd0, v_ovld[2]}, 32'd0);
        end
        if (last_cyc >= 0) begin
          chk($sformatf("stream%0d_spacing", got), 32'(cyc - last_cyc), 32'd11);
        end
        last_cyc = cyc;
        got++;
      end
      if (v_inrdy[2]) begin
        if (sent < 20) begin
          a1 = rand_normal();
          v_a[2]     = a1;
          v_valid[2] = 1'b1;
          refq.push_back(ref_op(a1, 1'b0));
          sent++;
        end else begin
          v_valid[2] = 1'b0;
        end
      end
    end
    v_valid[2] = 1'b0;
    chk("stream_count", 32'(got), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
